// File: rtl/aemb2_wsram.sv
// Dual-port byte-lane RAM for the aeMB2 instruction and data Wishbone ports.
// Per-port accept/ack controller with 1- or 2-cycle read latency, collision and forwarding rules.
module aemb2_wsram #(
  parameter int unsigned AW  = 14,
  parameter int unsigned LAT = 1,
  parameter int unsigned IWR = 0,
  parameter int unsigned FWD = 1
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic [AW-1:2] iwb_adr_o,
  input  logic [31:0]   iwb_dat_o,
  input  logic [3:0]    iwb_sel_o,
  input  logic          iwb_stb_o,
  input  logic          iwb_cyc_o,
  input  logic          iwb_wre_o,
  input  logic          iwb_tag_o,
  output logic [31:0]   iwb_dat_i,
  output logic          iwb_ack_i,
  input  logic [AW-1:2] mwb_adr_o,
  input  logic [31:0]   mwb_dat_o,
  input  logic [3:0]    mwb_sel_o,
  input  logic          mwb_stb_o,
  input  logic          mwb_cyc_o,
  input  logic          mwb_wre_o,
  input  logic          mwb_tag_o,
  output logic [31:0]   mwb_dat_i,
  output logic          mwb_ack_i
);

  localparam int unsigned DEPTH = 2 ** (AW - 2);
  localparam int unsigned NL    = 4;
  localparam bit          LAT2  = (LAT >= 2);
  localparam bit          IWR_EN = (IWR != 0);
  localparam bit          FWD_EN = (FWD != 0);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [31:0] mem [DEPTH];

  state_t      i_state, m_state;
  logic        i_cnt, m_cnt;
  logic [31:0] i_rd, m_rd;

  logic        i_acc, m_acc;
  logic [3:0]  i_wl, m_wl;
  logic [31:0] i_word, m_word, i_fwd;
  logic        fwd_hit;

  logic unused_tags;
  assign unused_tags = iwb_tag_o ^ mwb_tag_o;

  // Accept only from IDLE and never in a reset cycle, so reset-cycle writes are dropped.
  assign i_acc = !sys_rst_i && (i_state == IDLE) && iwb_stb_o && iwb_cyc_o;
  assign m_acc = !sys_rst_i && (m_state == IDLE) && mwb_stb_o && mwb_cyc_o;

  assign m_wl = mwb_sel_o & {NL{m_acc & mwb_wre_o}};
  assign i_wl = IWR_EN ? (iwb_sel_o & {NL{i_acc & iwb_wre_o}}) : 4'b0000;

  assign i_word = mem[iwb_adr_o];
  assign m_word = mem[mwb_adr_o];

  assign fwd_hit = FWD_EN && i_acc && !iwb_wre_o && m_acc && mwb_wre_o
                   && (iwb_adr_o == mwb_adr_o);

  // iwb read data, with same-cycle mwb write bytes merged in on the lanes mwb writes.
  always_comb begin
    i_fwd = i_word;
    for (int b = 0; b < 4; b++) begin
      if (fwd_hit && mwb_sel_o[b]) begin
        i_fwd[8*b +: 8] = mwb_dat_o[8*b +: 8];
      end
    end
  end

  // mwb is assigned last so it wins every lane both ports write on the same word.
  always_ff @(posedge sys_clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (i_wl[b]) mem[iwb_adr_o][8*b +: 8] <= iwb_dat_o[8*b +: 8];
      if (m_wl[b]) mem[mwb_adr_o][8*b +: 8] <= mwb_dat_o[8*b +: 8];
    end
  end

  // iwb controller: cnt marks the ack phase of a BUSY transaction.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      i_state   <= IDLE;
      i_cnt     <= 1'b0;
      i_rd      <= '0;
      iwb_ack_i <= 1'b0;
      iwb_dat_i <= '0;
    end else begin
      case (i_state)
        IDLE: begin
          if (i_acc) begin
            i_state <= BUSY;
            if (!LAT2) begin
              i_cnt     <= 1'b1;
              iwb_ack_i <= 1'b1;
              iwb_dat_i <= i_fwd;
            end else begin
              i_cnt <= 1'b0;
              i_rd  <= i_fwd;
            end
          end
        end
        BUSY: begin
          if (i_cnt) begin
            i_state   <= IDLE;
            i_cnt     <= 1'b0;
            iwb_ack_i <= 1'b0;
          end else if (!iwb_cyc_o) begin
            i_state <= IDLE;
          end else begin
            i_cnt     <= 1'b1;
            iwb_ack_i <= 1'b1;
            iwb_dat_i <= i_rd;
          end
        end
        default: i_state <= IDLE;
      endcase
    end
  end

  // mwb controller: same protocol, reads are always read-first.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      m_state   <= IDLE;
      m_cnt     <= 1'b0;
      m_rd      <= '0;
      mwb_ack_i <= 1'b0;
      mwb_dat_i <= '0;
    end else begin
      case (m_state)
        IDLE: begin
          if (m_acc) begin
            m_state <= BUSY;
            if (!LAT2) begin
              m_cnt     <= 1'b1;
              mwb_ack_i <= 1'b1;
              mwb_dat_i <= m_word;
            end else begin
              m_cnt <= 1'b0;
              m_rd  <= m_word;
            end
          end
        end
        BUSY: begin
          if (m_cnt) begin
            m_state   <= IDLE;
            m_cnt     <= 1'b0;
            mwb_ack_i <= 1'b0;
          end else if (!mwb_cyc_o) begin
            m_state <= IDLE;
          end else begin
            m_cnt     <= 1'b1;
            mwb_ack_i <= 1'b1;
            mwb_dat_i <= m_rd;
          end
        end
        default: m_state <= IDLE;
      endcase
    end
  end

endmodule
